// File: rtl/cpu_clk_seq_pkg.sv
// Shared encodings for the CPU clock sequencer: phase states (as shown on HEX) and run modes.
package cpu_clk_seq_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_HIGH = 2'd1,
        PH_LOW  = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        MODE_STEP  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_BURST = 2'd2
    } mode_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/cpu_clk_seq_timer.sv
// Phase timer: counts CLK cycles while running and pulses o_term on the last cycle of a phase.
module clk_phase_timer #(
    parameter int DIV_HALF = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_run,
    output logic o_term
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DIV_HALF - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_term = i_run && (r_cnt == TERM_CNT);

    // Held at zero while idle so every phase starts from a clean count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (!i_run || o_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_clk_sequencer.sv
// Sequenced CPU clock generator: single-step, free-run, N-cycle burst and PC breakpoint halt.
module cpu_clk_sequencer
    import cpu_clk_seq_pkg::*;
#(
    parameter int DIV_HALF = 25000000,
    parameter int CNT_W    = 25,
    parameter int PC_W     = 5,
    parameter int BURST_W  = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               STOP,
    input  logic               step_in,
    input  logic               run_in,
    input  logic               burst_in,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    pc_in,
    output logic               cpu_clk,
    output logic [1:0]         state,
    output logic [15:0]        cpu_cycles,
    output logic               bp_hit
);

    logic [1:0]         r_state;
    mode_t              r_mode;
    logic               r_cpu_clk;
    logic [15:0]        r_cycles;
    logic               r_bp_hit;
    logic [BURST_W-1:0] r_burst_rem;

    logic w_term;
    logic w_idle;
    logic w_burst_ok;
    logic w_accept;
    logic w_boundary;
    logic w_bp_match;
    logic w_free_mode;
    logic w_bp_halt;
    logic w_burst_done;
    logic w_continue;
    logic w_rise;

    clk_phase_timer #(
        .DIV_HALF (DIV_HALF),
        .CNT_W    (CNT_W)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .i_run  (r_state != ST_IDLE),
        .o_term (w_term)
    );

    assign w_idle     = (r_state == ST_IDLE);
    assign w_burst_ok = burst_in && (burst_len != '0);
    assign w_accept   = w_idle && !STOP && (run_in || w_burst_ok || step_in);

    // Boundary decision on the last LOW cycle; pc_in here is the PC from the preceding rise.
    assign w_boundary   = (r_state == ST_LOW) && w_term;
    assign w_bp_match   = bp_en && (pc_in == bp_addr);
    assign w_free_mode  = (r_mode == MODE_RUN) || (r_mode == MODE_BURST);
    assign w_bp_halt    = w_boundary && !STOP && w_free_mode && w_bp_match;
    assign w_burst_done = (r_mode == MODE_BURST) && (r_burst_rem == '0);
    assign w_continue   = w_boundary && !STOP && w_free_mode && !w_bp_match && !w_burst_done;
    assign w_rise       = w_accept || w_continue;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cpu_clk <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_HIGH;
                        r_cpu_clk <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_term) begin
                        r_state   <= ST_LOW;
                        r_cpu_clk <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (w_term) begin
                        if (w_continue) begin
                            r_state   <= ST_HIGH;
                            r_cpu_clk <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cpu_clk <= 1'b0;
                end
            endcase
        end
    end

    // Mode is chosen on acceptance; run_in while busy upgrades any mode to free-run.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mode <= MODE_STEP;
        end else if (w_accept) begin
            if (run_in) begin
                r_mode <= MODE_RUN;
            end else if (w_burst_ok) begin
                r_mode <= MODE_BURST;
            end else begin
                r_mode <= MODE_STEP;
            end
        end else if (!w_idle && run_in) begin
            r_mode <= MODE_RUN;
        end
    end

    // Remaining rises after the current one; the accepting rise consumes one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_burst_rem <= '0;
        end else if (w_accept && !run_in && w_burst_ok) begin
            r_burst_rem <= burst_len - BURST_W'(1);
        end else if (w_continue && (r_mode == MODE_BURST)) begin
            r_burst_rem <= r_burst_rem - BURST_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cycles <= 16'd0;
        end else if (w_rise) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bp_hit <= 1'b0;
        end else if (w_accept) begin
            r_bp_hit <= 1'b0;
        end else if (w_bp_halt) begin
            r_bp_hit <= 1'b1;
        end
    end

    assign cpu_clk    = r_cpu_clk;
    assign state      = r_state;
    assign cpu_cycles = r_cycles;
    assign bp_hit     = r_bp_hit;

endmodule

// File: tb/tb_cpu_clk_sequencer.sv
// Directed bench for cpu_clk_sequencer with DIV_HALF = 2 and a PC that advances on each cpu_clk rise.
module tb_cpu_clk_sequencer;

    localparam int PC_W    = 5;
    localparam int BURST_W = 8;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               STOP = 1'b0;
    logic               step_in = 1'b0;
    logic               run_in = 1'b0;
    logic               burst_in = 1'b0;
    logic [BURST_W-1:0] burst_len = '0;
    logic               bp_en = 1'b0;
    logic [PC_W-1:0]    bp_addr = '0;
    logic [PC_W-1:0]    pc_in;
    logic               cpu_clk;
    logic [1:0]         state;
    logic [15:0]        cpu_cycles;
    logic               bp_hit;

    int n_total = 0;
    int n_bad   = 0;
    int rise_cnt = 0;
    int pc_base  = 0;
    int n;
    int r0;

    cpu_clk_sequencer #(
        .DIV_HALF (2),
        .CNT_W    (2),
        .PC_W     (PC_W),
        .BURST_W  (BURST_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .STOP       (STOP),
        .step_in    (step_in),
        .run_in     (run_in),
        .burst_in   (burst_in),
        .burst_len  (burst_len),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc_in      (pc_in),
        .cpu_clk    (cpu_clk),
        .state      (state),
        .cpu_cycles (cpu_cycles),
        .bp_hit     (bp_hit)
    );

    always #5 CLK = ~CLK;

    always @(posedge cpu_clk) rise_cnt <= rise_cnt + 1;

    assign pc_in = PC_W'(rise_cnt - pc_base);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input int max, output int cnt);
        cnt = 0;
        while (state != 2'd0 && cnt < max) begin
            tick();
            cnt++;
        end
        if (state != 2'd0) chk("idle_timeout", state, 0);
    endtask

    task automatic pulse_step();
        step_in = 1'b1; tick(); step_in = 1'b0;
    endtask

    task automatic pulse_run();
        run_in = 1'b1; tick(); run_in = 1'b0;
    endtask

    task automatic pulse_burst(input int len);
        burst_len = BURST_W'(len);
        burst_in = 1'b1; tick(); burst_in = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_clk", cpu_clk, 0);
        chk("rst_state", state, 0);
        chk("rst_cycles", cpu_cycles, 0);
        chk("rst_bp", bp_hit, 0);
        RST = 1'b0;
        tick();

        // Single step, second step during HIGH ignored
        pulse_step();
        chk("step_clk_hi", cpu_clk, 1);
        chk("step_state_hi", state, 1);
        chk("step_cycles", cpu_cycles, 1);
        pulse_step();
        chk("step_ign_state", state, 1);
        tick();
        chk("step_low_clk", cpu_clk, 0);
        chk("step_low_state", state, 2);
        wait_idle(20, n);
        chk("step_len", n, 2);
        chk("step_cycles_end", cpu_cycles, 1);

        // Burst of 3, then zero-length burst
        r0 = rise_cnt;
        pulse_burst(3);
        chk("burst_state", state, 1);
        wait_idle(100, n);
        chk("burst_len_clk", n, 12);
        chk("burst_rises", rise_cnt - r0, 3);
        chk("burst_cycles", cpu_cycles, 4);
        pulse_burst(0);
        chk("burst0_state", state, 0);
        tick();
        chk("burst0_cycles", cpu_cycles, 4);

        // Run, STOP raised mid-HIGH of the 4th cycle
        pulse_run();
        repeat (12) tick();
        chk("run_4th_clk", cpu_clk, 1);
        chk("run_4th_cycles", cpu_cycles, 8);
        STOP = 1'b1;
        wait_idle(100, n);
        chk("run_stop_len", n, 4);
        chk("run_stop_cycles", cpu_cycles, 8);
        pulse_run();
        chk("stop_blocks_state", state, 0);
        tick();
        chk("stop_blocks_cycles", cpu_cycles, 8);
        STOP = 1'b0;
        tick();

        // Breakpoint at pc 5, then resume past it
        pc_base = rise_cnt;
        bp_en = 1'b1;
        bp_addr = 5'd5;
        tick();
        chk("bp_pc_start", pc_in, 0);
        pulse_run();
        wait_idle(200, n);
        chk("bp_len", n, 20);
        chk("bp_pc", pc_in, 5);
        chk("bp_hit", bp_hit, 1);
        chk("bp_cycles", cpu_cycles, 13);
        pulse_run();
        chk("bp_clear", bp_hit, 0);
        repeat (10) tick();
        chk("bp_resume_pc", pc_in, 8);
        chk("bp_resume_state", state, 2);
        STOP = 1'b1;
        wait_idle(100, n);
        STOP = 1'b0;
        chk("bp_resume_cycles", cpu_cycles, 16);
        chk("bp_resume_hit", bp_hit, 0);
        bp_en = 1'b0;
        tick();

        // Simultaneous commands: run wins
        burst_len = 8'd1;
        run_in = 1'b1; burst_in = 1'b1; step_in = 1'b1;
        tick();
        run_in = 1'b0; burst_in = 1'b0; step_in = 1'b0;
        repeat (8) tick();
        chk("simul_state", state, 1);
        chk("simul_cycles", cpu_cycles, 19);
        STOP = 1'b1;
        wait_idle(100, n);
        STOP = 1'b0;
        chk("simul_end_cycles", cpu_cycles, 19);
        tick();

        // Async reset mid-LOW of a burst
        pulse_burst(10);
        chk("rb_cycles", cpu_cycles, 20);
        repeat (6) tick();
        chk("rb_pre_state", state, 2);
        chk("rb_pre_cycles", cpu_cycles, 21);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_clk", cpu_clk, 0);
        chk("ar_state", state, 0);
        chk("ar_cycles", cpu_cycles, 0);
        RST = 1'b0;
        tick();
        chk("ar_hold_state", state, 0);
        pulse_step();
        chk("ar_step_cycles", cpu_cycles, 1);
        wait_idle(20, n);
        chk("ar_step_len", n, 4);
        chk("ar_step_end", cpu_cycles, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
